// File: rtl/amns_mm_sequencer.sv
// amns_mm_sequencer: control FSM scheduling one AMNS modular multiplication
// (load, S blocks of N-cycle multiply then N-cycle reduce, drain, latch, store).
module amns_mm_sequencer #(
  parameter int WORD_WIDTH = 17,
  parameter int N          = 5,
  parameter int S          = 4,
  parameter int PIPE_LAT   = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         load_done_i,
  input  logic         store_done_i,
  output logic         load_start_o,
  output logic         store_start_o,
  output logic [S-1:0] A_reg_coeff_rot_o,
  output logic         B_reg_shift_o,
  output logic         M_reg_shift_o,
  output logic         M_prime_0_reg_rot_o,
  output logic         load_RES_reg_en_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         error_o
);
  localparam int IW = S > 1 ? $clog2(S) : 1;
  localparam int JW = N > 1 ? $clog2(N) : 1;
  localparam int DW = PIPE_LAT > 1 ? $clog2(PIPE_LAT) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  if (WORD_WIDTH < 1 || N < 1 || S < 1 || PIPE_LAT < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("amns_mm_sequencer: invalid parameters");
  end
  typedef enum logic [3:0] {
    IDLE, LOAD_REQ, LOAD_WAIT, MULT, REDUC, DRAIN, LATCH, STORE_REQ, STORE_WAIT, DONE
  } state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [DW-1:0] d_q, d_d;
  logic [WW-1:0] w_q, w_d;
  logic          err_q, err_d;
  logic          last_j, timed_out;
  logic          load_q, store_q, b_q, m_q, mp_q, res_q, busy_q, done_q;
  logic [S-1:0]  rot_q;
  assign last_j    = j_q == JW'(N - 1);
  assign timed_out = w_q == WW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    d_d     = d_q;
    w_d     = w_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = LOAD_REQ;
        err_d   = 1'b0;
        i_d     = '0;
        j_d     = '0;
      end
      LOAD_REQ: begin
        state_d = LOAD_WAIT;
        w_d     = '0;
      end
      LOAD_WAIT: if (load_done_i) begin
        state_d = MULT;
        i_d     = '0;
        j_d     = '0;
      end else if (timed_out) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else w_d = w_q + 1'b1;
      MULT: begin
        j_d     = last_j ? '0 : j_q + 1'b1;
        state_d = last_j ? REDUC : MULT;
      end
      REDUC: begin
        j_d = last_j ? '0 : j_q + 1'b1;
        if (last_j && i_q == IW'(S - 1)) begin
          state_d = DRAIN;
          d_d     = '0;
        end else if (last_j) begin
          state_d = MULT;
          i_d     = i_q + 1'b1;
        end
      end
      DRAIN: if (d_q == DW'(PIPE_LAT - 1)) state_d = LATCH;
             else d_d = d_q + 1'b1;
      LATCH: state_d = STORE_REQ;
      STORE_REQ: begin
        state_d = STORE_WAIT;
        w_d     = '0;
      end
      STORE_WAIT: if (store_done_i) state_d = DONE;
                  else if (timed_out) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                  end else w_d = w_q + 1'b1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so each flop lines up with its state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      d_q     <= '0;
      w_q     <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      rot_q   <= '0;
      b_q     <= 1'b0;
      m_q     <= 1'b0;
      mp_q    <= 1'b0;
      res_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      d_q     <= d_d;
      w_q     <= w_d;
      err_q   <= err_d;
      load_q  <= state_d == LOAD_REQ;
      store_q <= state_d == STORE_REQ;
      rot_q   <= state_d == MULT ? S'(1) << i_d : '0;
      b_q     <= state_d == MULT;
      m_q     <= state_d == REDUC;
      mp_q    <= state_d == REDUC && j_d == '0;
      res_q   <= state_d == LATCH;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
    end
  end
  assign load_start_o        = load_q;
  assign store_start_o       = store_q;
  assign A_reg_coeff_rot_o   = rot_q;
  assign B_reg_shift_o       = b_q;
  assign M_reg_shift_o       = m_q;
  assign M_prime_0_reg_rot_o = mp_q;
  assign load_RES_reg_en_o   = res_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign error_o             = err_q;
endmodule

// File: tb/tb_amns_mm_sequencer.sv
// tb_amns_mm_sequencer: table-driven sequence checks plus hand-written
// timeout and mid-sequence reset scenarios for amns_mm_sequencer.
module tb_amns_mm_sequencer;
  logic clock_i = 1'b0, reset_i = 1'b1, start_i = 1'b0, load_done_i = 1'b0, store_done_i = 1'b0;
  logic load_start_o, store_start_o, B_reg_shift_o, M_reg_shift_o, M_prime_0_reg_rot_o;
  logic load_RES_reg_en_o, busy_o, done_o, error_o;
  logic [3:0] A_reg_coeff_rot_o;
  logic [12:0] outs;
  int total = 0, bad = 0;
  amns_mm_sequencer dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
    .load_done_i(load_done_i), .store_done_i(store_done_i),
    .load_start_o(load_start_o), .store_start_o(store_start_o),
    .A_reg_coeff_rot_o(A_reg_coeff_rot_o), .B_reg_shift_o(B_reg_shift_o),
    .M_reg_shift_o(M_reg_shift_o), .M_prime_0_reg_rot_o(M_prime_0_reg_rot_o),
    .load_RES_reg_en_o(load_RES_reg_en_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );
  assign outs = {load_start_o, store_start_o, A_reg_coeff_rot_o, B_reg_shift_o, M_reg_shift_o,
                 M_prime_0_reg_rot_o, load_RES_reg_en_o, busy_o, done_o, error_o};
  always #5 clock_i = ~clock_i;
  typedef struct {
    int hold, spur, ld_dly, st_dly;
    int e_ld, e_b, e_m, e_mp, e_st, e_done, e_err;
  } vec_t;
  vec_t vt[6];
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic run_seq(input vec_t v);
    int ld_n = 0, st_n = 0, b_n = 0, m_n = 0, mp_n = 0, res_n = 0, done_n = 0, ctrl_n = 0;
    int rot_bad = 0, both_n = 0;
    int ld_at = -1, st_at = -1, res_at = -1, done_at = -1, err_at = -1, first_c = -1, last_c = -1;
    bit fin = 0;
    logic [3:0] e_rot;
    start_i = 1'b1;
    for (int cyc = 0; cyc < 700 && !fin; cyc++) begin
      @(negedge clock_i);
      if (cyc == 0) chk("err_clear_on_start", error_o, 0);
      if (load_start_o) begin ld_n++; ld_at = cyc; end
      if (store_start_o) begin st_n++; st_at = cyc; end
      if (B_reg_shift_o) begin
        e_rot = 4'b0001 << (b_n / 5);
        if (A_reg_coeff_rot_o != e_rot) rot_bad++;
        b_n++;
      end else if (A_reg_coeff_rot_o != 4'b0) rot_bad++;
      if (M_reg_shift_o) m_n++;
      if (B_reg_shift_o && M_reg_shift_o) both_n++;
      if (B_reg_shift_o || M_reg_shift_o) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        ctrl_n++;
      end
      if (M_prime_0_reg_rot_o) mp_n++;
      if (load_RES_reg_en_o) begin res_n++; res_at = cyc; end
      if (done_o) begin done_n++; done_at = cyc; end
      if (error_o && err_at < 0) err_at = cyc;
      if (!busy_o) fin = 1;
      start_i      = (v.hold != 0 && done_n == 0) ? 1'b1 : 1'b0;
      load_done_i  = (ld_at >= 0 && cyc == ld_at + v.ld_dly) || (v.spur != 0 && B_reg_shift_o);
      store_done_i = (st_at >= 0 && cyc == st_at + v.st_dly) || (v.spur != 0 && B_reg_shift_o);
    end
    start_i = 1'b0;
    load_done_i = 1'b0;
    store_done_i = 1'b0;
    chk("seq_finished", fin, 1);
    chk("load_pulses", ld_n, v.e_ld);
    chk("b_shift_count", b_n, v.e_b);
    chk("m_shift_count", m_n, v.e_m);
    chk("mprime_pulses", mp_n, v.e_mp);
    chk("ctrl_cycles", ctrl_n, 40);
    chk("ctrl_no_gaps", last_c - first_c + 1, 40);
    chk("rot_schedule_bad", rot_bad, 0);
    chk("b_and_m_overlap", both_n, 0);
    chk("first_ctrl_latency", first_c, ld_at + v.ld_dly + 1);
    chk("drain_cycles", res_at - last_c - 1, 4);
    chk("res_en_pulses", res_n, 1);
    chk("store_pulses", st_n, v.e_st);
    chk("store_after_latch", st_at, res_at + 1);
    chk("done_pulses", done_n, v.e_done);
    chk("error_final", error_o, v.e_err);
    if (v.e_done != 0) chk("done_latency", done_at, st_at + v.st_dly + 1);
    else chk("store_timeout_at", err_at, st_at + 256);
  endtask
  initial begin
    vt[0] = '{0, 0, 5, 3, 1, 20, 20, 4, 1, 1, 0};
    vt[1] = '{1, 1, 5, 3, 1, 20, 20, 4, 1, 1, 0};
    vt[2] = '{0, 0, 1, 1, 1, 20, 20, 4, 1, 1, 0};
    vt[3] = '{0, 0, 255, 255, 1, 20, 20, 4, 1, 1, 0};
    vt[4] = '{0, 0, 4, 256, 1, 20, 20, 4, 1, 0, 1};
    vt[5] = '{0, 0, 2, 9, 1, 20, 20, 4, 1, 1, 0};
    start_i = 1'b1;
    repeat (3) @(negedge clock_i);
    chk("outs_in_reset", outs, 0);
    start_i = 1'b0;
    reset_i = 1'b0;
    @(negedge clock_i);
    chk("outs_idle", outs, 0);
    for (int k = 0; k < 6; k++) run_seq(vt[k]);
    begin : load_timeout
      int ld_at = -1, err_at = -1, dn = 0;
      bit fin = 0;
      start_i = 1'b1;
      for (int c = 0; c < 400 && !fin; c++) begin
        @(negedge clock_i);
        start_i = 1'b0;
        if (load_start_o && ld_at < 0) ld_at = c;
        if (done_o) dn++;
        if (error_o && err_at < 0) err_at = c;
        if (!busy_o) fin = 1;
      end
      chk("to_finished", fin, 1);
      chk("to_error_at", err_at, ld_at + 256);
      chk("to_done", dn, 0);
      chk("to_busy", busy_o, 0);
      @(negedge clock_i);
      chk("to_error_sticky", error_o, 1);
    end
    run_seq(vt[0]);
    begin : reset_mid
      int ld_at = -1, bn = 0;
      bit hit = 0;
      start_i = 1'b1;
      for (int c = 0; c < 100 && !hit; c++) begin
        @(negedge clock_i);
        start_i = 1'b0;
        if (load_start_o) ld_at = c;
        load_done_i = ld_at >= 0 && c == ld_at + 5;
        if (B_reg_shift_o) bn++;
        if (bn == 10) hit = 1;
      end
      chk("reached_mult10", hit, 1);
      load_done_i = 1'b0;
      reset_i = 1'b1;
      @(negedge clock_i);
      chk("outs_after_mid_reset", outs, 0);
      reset_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clock_i);
        chk("outs_quiet_after_reset", outs, 0);
      end
    end
    run_seq(vt[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
